// File: rtl/energy_term_gen.sv
// Ising energy row-term generator: latches a spin vector, consumes one coupling row per
// handshake and emits s_r * sum_c(s_c * J[r][c]). Option: ENERGY_TERM_GEN_DIAG_SKIP_EN.
module energy_term_gen #(
  parameter int unsigned NUM_SPIN  = 16,
  parameter int unsigned J_WIDTH   = 4,
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic                          clear_i,
  input  logic                          start_i,
  input  logic [NUM_SPIN-1:0]           spin_i,
  input  logic                          j_valid_i,
  output logic                          j_ready_o,
  input  logic [NUM_SPIN*J_WIDTH-1:0]   j_row_i,
  output logic signed [OUT_WIDTH-1:0]   term_o,
  output logic                          term_valid_o,
  output logic                          last_o,
  output logic                          busy_o
);

  localparam int unsigned RW        = (NUM_SPIN > 1) ? $clog2(NUM_SPIN) : 1;
  localparam int unsigned MIN_OUT_W = J_WIDTH + $clog2(NUM_SPIN) + 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(NUM_SPIN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_e;

  generate
    if (OUT_WIDTH < MIN_OUT_W) begin : g_width_check
      $error("energy_term_gen: OUT_WIDTH too narrow for exact row terms");
    end
  endgenerate

  state_e                       state_q, state_d;
  logic [RW-1:0]                r_q, r_d;
  logic [NUM_SPIN-1:0]          spin_q, spin_d;
  logic signed [OUT_WIDTH-1:0]  term_q, term_d;
  logic                         tv_q, tv_d;
  logic                         last_q, last_d;

  logic                         hs;
  logic signed [OUT_WIDTH-1:0]  j_ext;
  logic signed [OUT_WIDTH-1:0]  row_sum;
  logic signed [OUT_WIDTH-1:0]  row_term;

  // clear_i wins over a handshake presented in the same cycle
  assign hs = (state_q == ST_RUN) && en_i && j_valid_i && !clear_i;

  // State register and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      spin_q  <= '0;
      term_q  <= '0;
      tv_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      spin_q  <= spin_d;
      term_q  <= term_d;
      tv_q    <= tv_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (en_i) begin
      if (clear_i) begin
        state_d = ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE:  if (start_i) state_d = ST_RUN;
          ST_RUN:   if (hs && (r_q == LAST_ROW)) state_d = ST_FLUSH;
          ST_FLUSH: state_d = ST_IDLE;
          default:  state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Row arithmetic; widths are sized so negating the most negative J stays exact
  always_comb begin
    row_sum = '0;
    j_ext   = '0;
    for (int c = 0; c < NUM_SPIN; c++) begin
      j_ext = OUT_WIDTH'($signed(j_row_i[c*J_WIDTH +: J_WIDTH]));
`ifdef ENERGY_TERM_GEN_DIAG_SKIP_EN
      if (RW'(c) == r_q) j_ext = '0;
`endif
      row_sum = spin_q[c] ? (row_sum + j_ext) : (row_sum - j_ext);
    end
    row_term = spin_q[r_q] ? row_sum : -row_sum;
  end

  // Output / datapath next values; everything holds while en_i is low
  always_comb begin
    r_d    = r_q;
    spin_d = spin_q;
    term_d = term_q;
    tv_d   = tv_q;
    last_d = last_q;
    if (en_i) begin
      tv_d   = 1'b0;
      last_d = 1'b0;
      if (clear_i) begin
        r_d = '0;
      end else if ((state_q == ST_IDLE) && start_i) begin
        spin_d = spin_i;
        r_d    = '0;
      end else if (hs) begin
        term_d = row_term;
        tv_d   = 1'b1;
        last_d = (r_q == LAST_ROW);
        r_d    = (r_q == LAST_ROW) ? '0 : r_q + RW'(1);
      end
    end
  end

  assign j_ready_o    = (state_q == ST_RUN) && en_i;
  assign term_o       = term_q;
  assign term_valid_o = tv_q && en_i;
  assign last_o       = last_q && en_i;
  assign busy_o       = (state_q != ST_IDLE) || tv_q;

endmodule
